// File: rtl/bias_relu_stage_pkg.sv
// bias_relu_stage_pkg
// Definitions shared by the per-layer CNN stages: the default lane width,
// the saturation limits for that width, and a helper that locates a lane
// inside a packed multi-lane vector.
package bias_relu_stage_pkg;

  // Default lane width: two's complement, same format as the bias banks.
  localparam int LANE_DW = 18;

  // Saturation limits for a LANE_DW-bit signed lane.
  localparam logic signed [LANE_DW-1:0] SAT_MAX = {1'b0, {(LANE_DW-1){1'b1}}};
  localparam logic signed [LANE_DW-1:0] SAT_MIN = {1'b1, {(LANE_DW-1){1'b0}}};

  // Lowest bit index of lane 'lane' in a vector of 'dw'-bit lanes,
  // lane 0 in the least significant position.
  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/bias_sat_lane.sv
// bias_sat_lane
// Combinational datapath for one lane. It is split around the stage-1
// register held by the parent:
//   front half : sum = sign-extended in_lane + bias_lane (DW+1 bits, exact)
//   back half  : out_lane = saturate(sum_q) to DW bits, then optional ReLU
// Ports:
//   in_lane   in  DW    adder-tree partial sum for this lane
//   bias_lane in  DW    bias value for this lane
//   sum       out DW+1  exact sum, to be registered by the parent
//   sum_q     in  DW+1  registered sum from the parent's stage-1 register
//   relu_q    in  1     registered ReLU enable travelling with sum_q
//   out_lane  out DW    saturated, optionally ReLU'd result
module bias_sat_lane
  import bias_relu_stage_pkg::*;
#(
  parameter int DW = LANE_DW
) (
  input  logic [DW-1:0] in_lane,
  input  logic [DW-1:0] bias_lane,
  output logic [DW:0]   sum,
  input  logic [DW:0]   sum_q,
  input  logic          relu_q,
  output logic [DW-1:0] out_lane
);

  localparam logic [DW-1:0] LANE_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] LANE_MIN = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] sat;

  // One extra bit makes the addition of two DW-bit values exact.
  assign sum = {in_lane[DW-1], in_lane} + {bias_lane[DW-1], bias_lane};

  // The DW+1-bit sum is out of DW-bit range exactly when its top two bits
  // disagree; the top bit then gives the direction of the overflow.
  always_comb begin
    sat = sum_q[DW-1:0];
    if (sum_q[DW] != sum_q[DW-1]) begin
      sat = sum_q[DW] ? LANE_MIN : LANE_MAX;
    end
  end

  assign out_lane = (relu_q && sat[DW-1]) ? '0 : sat;

endmodule

// File: rtl/bias_relu_stage.sv
// bias_relu_stage
// Adds a static bias vector to a beat of adder-tree sums, saturates each lane
// to DW bits, optionally applies ReLU, and forwards the result through a
// two-stage valid/ready pipeline. Output beats are counted per tile and
// tile_done pulses for one cycle after the last beat of each tile.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   relu_en    clamp negative results to 0 (captured with the beat)
//   bias       N_adder_tree x DW static bias lanes
//   in_data    N_adder_tree x DW adder-tree sums, in_valid / in_ready
//   out_data   N_adder_tree x DW results,        out_valid / out_ready
//   pix_cnt    output beats accepted so far in the current tile
//   tile_done  one-cycle pulse after the final beat of a tile
module bias_relu_stage
  import bias_relu_stage_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int DW           = LANE_DW,
  parameter int NUM_PIXELS   = 49,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      relu_en,
  input  logic [N_adder_tree*DW-1:0] bias,
  input  logic [N_adder_tree*DW-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_adder_tree*DW-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          pix_cnt,
  output logic                      tile_done
);

  localparam int SW = DW + 1;

  logic                          v1_reg;
  logic                          v2_reg;
  logic                          r1_reg;
  logic [N_adder_tree*SW-1:0]    s1_reg;
  logic [N_adder_tree*SW-1:0]    s1_next;
  logic [N_adder_tree*DW-1:0]    out_data_reg;
  logic [N_adder_tree*DW-1:0]    sat_next;
  logic [CNT_W-1:0]              pix_cnt_reg;
  logic                          tile_done_reg;
  logic                          en1;
  logic                          en2;
  logic                          out_fire;

  // Stage 2 may load when empty or being drained; stage 1 may load when
  // empty or when stage 2 is taking its contents this cycle.
  assign en2      = ~v2_reg | out_ready;
  assign en1      = ~v1_reg | en2;
  assign in_ready = en1;
  assign out_fire = v2_reg & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_adder_tree; gi++) begin : g_lane
      bias_sat_lane #(
        .DW(DW)
      ) u_lane (
        .in_lane  (in_data[lane_lo(gi, DW) +: DW]),
        .bias_lane(bias[lane_lo(gi, DW) +: DW]),
        .sum      (s1_next[lane_lo(gi, SW) +: SW]),
        .sum_q    (s1_reg[lane_lo(gi, SW) +: SW]),
        .relu_q   (r1_reg),
        .out_lane (sat_next[lane_lo(gi, DW) +: DW])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      r1_reg        <= 1'b0;
      s1_reg        <= '0;
      out_data_reg  <= '0;
      pix_cnt_reg   <= '0;
      tile_done_reg <= 1'b0;
    end else begin
      if (en1) begin
        v1_reg <= in_valid;
        r1_reg <= relu_en;
        if (in_valid) begin
          s1_reg <= s1_next;
        end
      end

      // Only loading on a valid stage-1 beat keeps out_data stable while
      // stage 2 holds or sits empty.
      if (en2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          out_data_reg <= sat_next;
        end
      end

      tile_done_reg <= 1'b0;
      if (out_fire) begin
        if (pix_cnt_reg == CNT_W'(NUM_PIXELS - 1)) begin
          pix_cnt_reg   <= '0;
          tile_done_reg <= 1'b1;
        end else begin
          pix_cnt_reg <= pix_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = v2_reg;
  assign pix_cnt   = pix_cnt_reg;
  assign tile_done = tile_done_reg;

endmodule

// File: tb/tb_bias_relu_stage.sv
module tb_bias_relu_stage;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int NP = 4;
  localparam int CW = 16;
  localparam int W  = N * DW;
  localparam int LMAX = 2 ** (DW - 1) - 1;
  localparam int LMIN = -(2 ** (DW - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          relu_en;
  logic [W-1:0]  bias;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] pix_cnt;
  logic          tile_done;

  int checks = 0;
  int errors = 0;

  // Reference state: beats in flight (expected results in order),
  // output beats in the current tile, expected tile_done.
  logic [W-1:0] exp_q[$];
  int           pc_model = 0;
  logic         td_model = 1'b0;
  logic         hold_valid = 1'b0;
  logic [W-1:0] hold_data;
  int           tile_pulses = 0;

  always #5 clk = ~clk;

  bias_relu_stage #(
    .N_adder_tree(N),
    .DW(DW),
    .NUM_PIXELS(NP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .relu_en(relu_en),
    .bias(bias),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pix_cnt(pix_cnt),
    .tile_done(tile_done)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected result of a beat: exact integer sum, clamp, optional ReLU.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] b,
                                         input logic r);
    logic [W-1:0] o;
    int s;
    o = '0;
    for (int i = 0; i < N; i++) begin
      s = int'($signed(d[i*DW +: DW])) + int'($signed(b[i*DW +: DW]));
      if (s > LMAX) s = LMAX;
      else if (s < LMIN) s = LMIN;
      if (r && s < 0) s = 0;
      o[i*DW +: DW] = s[DW-1:0];
    end
    return o;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // One clock: observe handshakes mid-cycle, update the model, then check
  // the registered counter outputs just after the edge.
  task automatic tick();
    logic ai, ao;
    logic [W-1:0] e;
    @(negedge clk);
    ai = in_valid & in_ready;
    ao = out_valid & out_ready;
    if (!rst) begin
      // Two beats of storage: stalls only when both slots are full and blocked.
      chk("in_ready", in_ready, (exp_q.size() < 2 || out_ready));
      if (exp_q.size() == 0) chk("out_valid_empty", out_valid, 1'b0);
      if (hold_valid) chk("stall_stable", {out_valid, out_data}, {1'b1, hold_data});
      if (ao) begin
        if (exp_q.size() == 0) chk("spurious_beat", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
      end
      if (ai) exp_q.push_back(model(in_data, bias, relu_en));
      hold_valid = out_valid & ~out_ready;
      hold_data  = out_data;
      td_model   = 1'b0;
      if (ao) begin
        if (pc_model == NP - 1) begin
          pc_model = 0;
          td_model = 1'b1;
        end else begin
          pc_model++;
        end
      end
    end else begin
      exp_q.delete();
      pc_model   = 0;
      td_model   = 1'b0;
      hold_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (tile_done === 1'b1) tile_pulses++;
    chk("tile_done", tile_done, td_model);
    chk("pix_cnt", pix_cnt, pc_model[CW-1:0]);
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid === 1'b1); k++) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  // Single beat with a known lane 0; lane 0 must show expv two cycles later.
  task automatic directed(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic r, input logic [DW-1:0] expv);
    logic [W-1:0] d, bb;
    d  = rand_vec();
    bb = rand_vec();
    d[DW-1:0]  = a;
    bb[DW-1:0] = b;
    in_data   = d;
    bias      = bb;
    relu_en   = r;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    relu_en  = ~r;
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk(tag, out_data[DW-1:0], expv);
    tick();
  endtask

  initial begin
    int sent;
    int cyc;
    rst       = 1'b1;
    relu_en   = 1'b0;
    bias      = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Directed arithmetic cases
    directed("basic_add", 18'd1000, 18'b111111110110000000, 1'b0, 18'd360);
    directed("sat_pos", 18'd131071, 18'd2, 1'b0, 18'h1FFFF);
    directed("sat_neg", 18'h20000, 18'h3FFFF, 1'b0, 18'h20000);
    directed("relu_on", 18'd100, 18'h3FD80, 1'b1, 18'd0);
    directed("relu_off", 18'd100, 18'h3FD80, 1'b0, 18'h3FDE4);
    drain("drain_directed");

    // Backpressure: 5 beats, sink stalls for 3 cycles starting at cycle 1
    bias = rand_vec();
    sent = 0;
    cyc  = 0;
    while ((sent < 5 || exp_q.size() != 0) && cyc < 60) begin
      in_valid  = (sent < 5);
      in_data   = rand_vec();
      relu_en   = 1'($urandom);
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (cyc == 3) chk("bp_in_ready_low", in_ready, 1'b0);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    drain("drain_bp");

    // Tile counting: fresh tile, 9 back-to-back beats
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tile_pulses = 0;
    sent = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sent < 9; k++) begin
      in_valid = 1'b1;
      in_data  = rand_vec();
      relu_en  = 1'($urandom);
      if (in_ready) sent++;
      tick();
    end
    drain("drain_tile");
    chk("tile_pulses", tile_pulses, 2);
    chk("tile_pix_after9", pix_cnt, 1);

    // Reset with both stages full
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = rand_vec();
    tick();
    in_data = rand_vec();
    tick();
    chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_tile", tile_done, 1'b0);
    tick();
    chk("post_rst_no_beat", out_valid, 1'b0);
    directed("after_rst", 18'd5, 18'd7, 1'b0, 18'd12);
    drain("drain_rst");

    // Random traffic
    bias = rand_vec();
    for (int k = 0; k < 200; k++) begin
      in_valid  = 1'($urandom);
      in_data   = rand_vec();
      relu_en   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
